intersection_scheduler: RTL

Two-approach intersection scheduler that shares right-of-way between a main road, a side road and a pedestrian crossing. It sequences both light heads and a walk signal through green, yellow, optional all-red and walk phases, timed in ticks from an external enable. Pedestrian requests are latched, and the main road rests in green when nothing is requesting. It sits above the per-head light logic and is the only block allowed to grant green.

---
 rtl/intersection_scheduler_pkg.sv | 34 +++
 rtl/intersection_scheduler_if.sv | 27 ++
 rtl/intersection_scheduler_phase_timer.sv | 38 +++
 rtl/intersection_scheduler.sv | 131 +++++++++++++
 4 files changed

// File: rtl/intersection_scheduler_pkg.sv
// Shared state and lamp encodings for the intersection scheduler.
// Build option: ALL_RED_EN enables the all-red clearance phases.
package intersection_pkg;

  typedef logic [2:0] state_t;

  localparam state_t MAIN_GREEN  = 3'd0;
  localparam state_t MAIN_YELLOW = 3'd1;
  localparam state_t ALL_RED_A   = 3'd2;
  localparam state_t PED_WALK    = 3'd3;
  localparam state_t SIDE_GREEN  = 3'd4;
  localparam state_t SIDE_YELLOW = 3'd5;
  localparam state_t ALL_RED_B   = 3'd6;

  localparam logic [2:0] RGY_RED = 3'b100;
  localparam logic [2:0] RGY_YEL = 3'b010;
  localparam logic [2:0] RGY_GRN = 3'b001;

  function automatic logic [2:0] head_rgy(
    input state_t s,
    input state_t grn,
    input state_t yel
  );
    logic [2:0] r;
    r = RGY_RED;
    unique case (1'b1)
      (s == grn): r = RGY_GRN;
      (s == yel): r = RGY_YEL;
      default:    r = RGY_RED;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/intersection_scheduler_if.sv
// Request/lamp bundle between the controller and the intersection heads.
// master drives the requests and tick, slave is the scheduler.
interface intersection_scheduler_if #(
  parameter int CNT_W = 8
) ();
  logic             tick;
  logic             side_req;
  logic             ped_req;
  logic [2:0]       main_rgy;
  logic [2:0]       side_rgy;
  logic             walk;
  logic             ped_ack;
  logic [2:0]       state;
  logic [CNT_W-1:0] timer;

  modport master (
    output tick, side_req, ped_req,
    input  main_rgy, side_rgy, walk,
    input  ped_ack, state, timer
  );

  modport slave (
    input  tick, side_req, ped_req,
    output main_rgy, side_rgy, walk,
    output ped_ack, state, timer
  );
endinterface

// File: rtl/intersection_scheduler_phase_timer.sv
// Loadable tick-enabled down-counter that saturates at zero.
// one flags the last tick of a timed phase.
module phase_timer #(
  parameter int               CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             one
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (tick && count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= RST_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign one   = (count_q == CNT_W'(1));

endmodule

// File: rtl/intersection_scheduler.sv
// Main/side/pedestrian right-of-way sequencer; sole grantor of green.
// Build option: ALL_RED_EN inserts the all-red clearance phases.
module intersection_scheduler
  import intersection_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int T_GREEN_MIN  = 20,
  parameter int T_YELLOW     = 4,
  parameter int T_ALLRED     = 2,
  parameter int T_SIDE_GREEN = 15,
  parameter int T_WALK       = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  intersection_scheduler_if.slave  bus
);

`ifdef ALL_RED_EN
  localparam bit ALL_RED = 1'b1;
`else
  localparam bit ALL_RED = 1'b0;
`endif

  localparam state_t RECOVER = ALL_RED ? ALL_RED_B : MAIN_GREEN;
  localparam state_t TO_MAIN = ALL_RED ? ALL_RED_B : MAIN_GREEN;

  state_t           state_q, state_d;
  logic             ped_pend_q, ped_pend_d;
  logic             ped_ack_q, ped_ack_d;
  logic [CNT_W-1:0] timer_val;
  logic [CNT_W-1:0] load_val;
  logic             timer_one;
  logic             load;
  logic             expire;
  logic             enter_walk;
  state_t           after_clear;

  assign expire      = bus.tick && timer_one;
  assign after_clear = ped_pend_q ? PED_WALK : SIDE_GREEN;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MAIN_GREEN:
        if (timer_val == '0 && (bus.side_req || ped_pend_q))
          state_d = MAIN_YELLOW;
      MAIN_YELLOW:
        if (expire)
          state_d = ALL_RED ? ALL_RED_A : after_clear;
      ALL_RED_A:
        if (!ALL_RED)
          state_d = RECOVER;
        else if (expire)
          state_d = after_clear;
      PED_WALK:
        if (expire)
          state_d = bus.side_req ? SIDE_GREEN : TO_MAIN;
      SIDE_GREEN:
        if (expire)
          state_d = SIDE_YELLOW;
      SIDE_YELLOW:
        if (expire)
          state_d = TO_MAIN;
      ALL_RED_B:
        if (!ALL_RED)
          state_d = RECOVER;
        else if (expire)
          state_d = MAIN_GREEN;
      default:
        state_d = RECOVER;
    endcase
  end

  // every entered phase reloads its own duration
  always_comb begin
    load_val = CNT_W'(T_GREEN_MIN);
    unique case (state_d)
      MAIN_GREEN:  load_val = CNT_W'(T_GREEN_MIN);
      MAIN_YELLOW: load_val = CNT_W'(T_YELLOW);
      ALL_RED_A:   load_val = CNT_W'(T_ALLRED);
      PED_WALK:    load_val = CNT_W'(T_WALK);
      SIDE_GREEN:  load_val = CNT_W'(T_SIDE_GREEN);
      SIDE_YELLOW: load_val = CNT_W'(T_YELLOW);
      ALL_RED_B:   load_val = CNT_W'(T_ALLRED);
      default:     load_val = CNT_W'(T_GREEN_MIN);
    endcase
  end

  assign load       = (state_d != state_q);
  assign enter_walk = load && (state_d == PED_WALK);

  // clearing on walk entry beats a coincident button press
  always_comb begin
    ped_pend_d = ped_pend_q | bus.ped_req;
    if (enter_walk) ped_pend_d = 1'b0;
    ped_ack_d = enter_walk;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= MAIN_GREEN;
      ped_pend_q <= 1'b0;
      ped_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ped_pend_q <= ped_pend_d;
      ped_ack_q  <= ped_ack_d;
    end
  end

  phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (CNT_W'(T_GREEN_MIN))
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .tick     (bus.tick),
    .load     (load),
    .load_val (load_val),
    .count    (timer_val),
    .one      (timer_one)
  );

  assign bus.main_rgy = head_rgy(state_q, MAIN_GREEN, MAIN_YELLOW);
  assign bus.side_rgy = head_rgy(state_q, SIDE_GREEN, SIDE_YELLOW);
  assign bus.walk     = (state_q == PED_WALK);
  assign bus.ped_ack  = ped_ack_q;
  assign bus.state    = state_q;
  assign bus.timer    = timer_val;

endmodule
